// File: rtl/uart_rx_oversampler.sv
// rtl/uart_rx_oversampler.sv - 16x oversampling UART receiver; optional parity bit via UART_RX_PARITY_EN
module uart_rx_oversampler #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int OVS     = 16
`ifdef UART_RX_PARITY_EN
    ,
    parameter int PARITY_ODD = 0
`endif
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tick,
    input  logic            rx,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            parity_err
);

    // The tick counter has to reach both the per-bit count and the stop-bit count
    localparam int S_MAX = (SB_TICK > OVS) ? SB_TICK : OVS;
    localparam int SW    = (S_MAX > 1) ? $clog2(S_MAX) : 1;
    localparam int NW    = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [SW-1:0] S_HALF = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] S_BIT  = SW'(OVS - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic       PAR_ODD   = (PARITY_ODD != 0);
`endif

    logic            rx_meta_q;
    logic            rx_s_q;

    logic [2:0]      state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            frame_done;

    logic [DBIT-1:0] dout_q;
    logic            done_q;
    logic            frame_err_q;

`ifdef UART_RX_PARITY_EN
    logic            p_bit_q, p_bit_d;
    logic            parity_err_q;
`endif

    // Two-flop synchroniser; resets to idle-high so reset release never looks like a start bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Frame sequencing: only the IDLE exit ignores tick, everything else steps on tick
    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        n_d        = n_q;
        b_d        = b_q;
        frame_done = 1'b0;
`ifdef UART_RX_PARITY_EN
        p_bit_d    = p_bit_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!rx_s_q) begin
                    state_d = ST_START;
                    s_d     = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (s_q == S_HALF) begin
                        // Line must still be low at mid start bit, otherwise it was a glitch
                        if (!rx_s_q) begin
                            state_d = ST_DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (s_q == S_BIT) begin
                        s_d = '0;
                        b_d = {rx_s_q, b_q[DBIT-1:1]};
                        if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    if (s_q == S_BIT) begin
                        s_d     = '0;
                        p_bit_d = rx_s_q;
                        state_d = ST_STOP;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    if (s_q == S_STOP) begin
                        state_d    = ST_IDLE;
                        frame_done = 1'b1;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Frame state, counters and shift register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
`ifdef UART_RX_PARITY_EN
            p_bit_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
`ifdef UART_RX_PARITY_EN
            p_bit_q <= p_bit_d;
`endif
        end
    end

    // Result registers: word and error flags update together with the one-clock done strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_q       <= '0;
            done_q       <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            done_q <= frame_done;
            if (frame_done) begin
                dout_q       <= b_q;
                frame_err_q  <= ~rx_s_q;
`ifdef UART_RX_PARITY_EN
                parity_err_q <= (^b_q) ^ p_bit_q ^ PAR_ODD;
`endif
            end
        end
    end

    assign dout         = dout_q;
    assign rx_done_tick = done_q;
    assign frame_err    = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err   = parity_err_q;
`else
    assign parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// tb/tb_uart_rx_oversampler.sv - directed bench for uart_rx_oversampler
module tb_uart_rx_oversampler;

    localparam int TICK_DIV = 4;
    localparam int BIT_CLK  = 16 * TICK_DIV;
`ifdef UART_RX_PARITY_EN
    localparam int LAT_MIN    = 672;
    localparam int BREAK_BITS = 22;
`else
    localparam int LAT_MIN    = 608;
    localparam int BREAK_BITS = 20;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       rx;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       frame_err;
    logic       parity_err;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int done_wide   = 0;
    logic done_prev = 1'b0;

    logic [9:0] rxq[$];
    int         done_cyc[$];

    always #5 clk = ~clk;

    uart_rx_oversampler dut (
        .clk          (clk),
        .reset        (reset),
        .tick         (tick),
        .rx           (rx),
        .dout         (dout),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err),
        .parity_err   (parity_err)
    );

    always @(posedge clk) cyc = cyc + 1;

    initial begin
        int cnt;
        cnt  = 0;
        tick = 1'b0;
        forever begin
            @(negedge clk);
            tick = (cnt == TICK_DIV - 1);
            cnt  = (cnt == TICK_DIV - 1) ? 0 : cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (rx_done_tick === 1'b1) begin
            rxq.push_back({parity_err, frame_err, dout});
            done_cyc.push_back(cyc);
            if (done_prev === 1'b1) done_wide = done_wide + 1;
        end
        done_prev = rx_done_tick;
    end

    function automatic logic [9:0] pop_entry();
        if (rxq.size() > 0) return rxq.pop_front();
        return 10'bx;
    endfunction

    task automatic clear_q();
        rxq.delete();
        done_cyc.delete();
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic par_bit);
        rx = 1'b0;
        wait_clk(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            wait_clk(BIT_CLK);
        end
`ifdef UART_RX_PARITY_EN
        rx = par_bit;
        wait_clk(BIT_CLK);
`endif
        rx = stop_bit;
        wait_clk(BIT_CLK * 3 / 4);
        rx = 1'b1;
        wait_clk(BIT_CLK / 4);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rx    = 1'b1;
        wait_clk(5);
        vectors++; if (dout !== 8'h00) begin miscompares++; $display("FAIL reset_dout: got %h expected 00", dout); end
        vectors++; if (rx_done_tick !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", rx_done_tick); end
        vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        vectors++; if (parity_err !== 1'b0) begin miscompares++; $display("FAIL reset_parity_err: got %b expected 0", parity_err); end
        reset = 1'b0;
        clear_q();
        wait_clk(2000);
        vectors++; if (rxq.size() !== 0) begin miscompares++; $display("FAIL idle_no_done: got %0d pulses expected 0", rxq.size()); end
        vectors++; if (dout !== 8'h00) begin miscompares++; $display("FAIL idle_dout: got %h expected 00", dout); end
    endtask

    task automatic test_basic();
        logic [9:0] e;
        int t0, lat;
        clear_q();
        t0 = cyc;
        send_frame(8'hA5, 1'b1, ^8'hA5);
        wait_clk(2 * BIT_CLK);
        vectors++; if (rxq.size() !== 1) begin miscompares++; $display("FAIL basic_count: got %0d expected 1", rxq.size()); end
        lat = (done_cyc.size() > 0) ? done_cyc[0] - t0 : -1;
        vectors++; if (lat < LAT_MIN - 2 || lat > LAT_MIN + 6) begin miscompares++; $display("FAIL basic_latency: got %0d clk expected %0d..%0d", lat, LAT_MIN - 2, LAT_MIN + 6); end
        e = pop_entry();
        vectors++; if (e !== {2'b00, 8'hA5}) begin miscompares++; $display("FAIL basic_word: got %h expected %h", e, {2'b00, 8'hA5}); end
        vectors++; if (dout !== 8'hA5) begin miscompares++; $display("FAIL basic_dout_hold: got %h expected a5", dout); end
    endtask

    task automatic test_glitch();
        logic [9:0] e;
        clear_q();
        rx = 1'b0;
        wait_clk(4 * TICK_DIV);
        rx = 1'b1;
        wait_clk(2 * BIT_CLK);
        vectors++; if (rxq.size() !== 0) begin miscompares++; $display("FAIL glitch_rejected: got %0d pulses expected 0", rxq.size()); end
        send_frame(8'h3C, 1'b1, ^8'h3C);
        wait_clk(2 * BIT_CLK);
        vectors++; if (rxq.size() !== 1) begin miscompares++; $display("FAIL glitch_next_count: got %0d expected 1", rxq.size()); end
        e = pop_entry();
        vectors++; if (e !== {2'b00, 8'h3C}) begin miscompares++; $display("FAIL glitch_next_word: got %h expected %h", e, {2'b00, 8'h3C}); end
    endtask

    task automatic test_frame_err();
        logic [9:0] e;
        clear_q();
        send_frame(8'h55, 1'b0, ^8'h55);
        wait_clk(2 * BIT_CLK);
        vectors++; if (rxq.size() !== 1) begin miscompares++; $display("FAIL ferr_count: got %0d expected 1", rxq.size()); end
        e = pop_entry();
        vectors++; if (e !== {2'b01, 8'h55}) begin miscompares++; $display("FAIL ferr_word: got %h expected %h", e, {2'b01, 8'h55}); end
        vectors++; if (frame_err !== 1'b1) begin miscompares++; $display("FAIL ferr_hold: got %b expected 1", frame_err); end
        send_frame(8'h0F, 1'b1, ^8'h0F);
        wait_clk(2 * BIT_CLK);
        e = pop_entry();
        vectors++; if (e !== {2'b00, 8'h0F}) begin miscompares++; $display("FAIL ferr_clear_word: got %h expected %h", e, {2'b00, 8'h0F}); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_w[3];
        logic [9:0] e;
        exp_w[0] = 8'h00;
        exp_w[1] = 8'hFF;
        exp_w[2] = 8'h81;
        clear_q();
        done_wide = 0;
        for (int i = 0; i < 3; i++) send_frame(exp_w[i], 1'b1, ^exp_w[i]);
        wait_clk(2 * BIT_CLK);
        vectors++; if (rxq.size() !== 3) begin miscompares++; $display("FAIL b2b_count: got %0d expected 3", rxq.size()); end
        for (int i = 0; i < 3; i++) begin
            e = pop_entry();
            vectors++; if (e !== {2'b00, exp_w[i]}) begin miscompares++; $display("FAIL b2b_word%0d: got %h expected %h", i, e, {2'b00, exp_w[i]}); end
        end
        vectors++; if (done_wide !== 0) begin miscompares++; $display("FAIL done_width: got %0d wide pulses expected 0", done_wide); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        logic [9:0] e;
        d = 8'h77;
        clear_q();
        rx = 1'b0;
        wait_clk(BIT_CLK);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            wait_clk(BIT_CLK);
        end
        rx = d[4];
        wait_clk(BIT_CLK / 2);
        reset = 1'b1;
        rx    = 1'b1;
        wait_clk(5);
        reset = 1'b0;
        vectors++; if (dout !== 8'h00) begin miscompares++; $display("FAIL midreset_dout: got %h expected 00", dout); end
        wait_clk(3 * BIT_CLK);
        vectors++; if (rxq.size() !== 0) begin miscompares++; $display("FAIL midreset_no_done: got %0d expected 0", rxq.size()); end
        send_frame(8'h12, 1'b1, ^8'h12);
        wait_clk(2 * BIT_CLK);
        e = pop_entry();
        vectors++; if (e !== {2'b00, 8'h12}) begin miscompares++; $display("FAIL midreset_next_word: got %h expected %h", e, {2'b00, 8'h12}); end
    endtask

    task automatic test_break();
        logic [9:0] e;
        clear_q();
        rx = 1'b0;
        wait_clk(BREAK_BITS * BIT_CLK);
        vectors++; if (rxq.size() !== 2) begin miscompares++; $display("FAIL break_count: got %0d expected 2", rxq.size()); end
        for (int i = 0; i < 2; i++) begin
            e = pop_entry();
            vectors++; if (e[8:0] !== 9'h100) begin miscompares++; $display("FAIL break_word%0d: got %h expected fe=1 dout=00", i, e[8:0]); end
        end
        reset = 1'b1;
        rx    = 1'b1;
        wait_clk(5);
        reset = 1'b0;
        wait_clk(2 * BIT_CLK);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        logic [9:0] e;
        clear_q();
        send_frame(8'h07, 1'b1, 1'b1);
        wait_clk(2 * BIT_CLK);
        e = pop_entry();
        vectors++; if (e !== {2'b00, 8'h07}) begin miscompares++; $display("FAIL parity_good: got %h expected %h", e, {2'b00, 8'h07}); end
        send_frame(8'h07, 1'b1, 1'b0);
        wait_clk(2 * BIT_CLK);
        e = pop_entry();
        vectors++; if (e !== {2'b10, 8'h07}) begin miscompares++; $display("FAIL parity_bad: got %h expected %h", e, {2'b10, 8'h07}); end
    endtask
`endif

    initial begin
        reset = 1'b1;
        rx    = 1'b1;
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_mid();
        test_break();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
